// File: rtl/top_pkg.sv
// Shared constants and types for the digit-classification input-image buffer.
package top_pkg;

   localparam int unsigned IMG_SIDE  = 28;
   localparam int unsigned IMG_DEPTH = IMG_SIDE * IMG_SIDE;
   localparam int unsigned PIX_W     = 16;
   localparam int unsigned ADDR_W    = 16;

   typedef logic [PIX_W-1:0]  pixel_t;
   typedef logic [ADDR_W-1:0] addr_t;

endpackage : top_pkg

// File: rtl/sram_sp.sv
// Single-port synchronous RAM: registered read, no reset on the array.
// The read register has a synchronous clear so the wrapper can zero rdata
// without adding a second pipeline stage.
module sram_sp
   import top_pkg::*;
#(
   parameter int unsigned DEPTH  = IMG_DEPTH,
   parameter int unsigned DATA_W = PIX_W,
   parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_clr,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Array write; contents survive reset
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   // Read register: clear wins, otherwise load on read, hold on write/idle
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_idx];
      end
   end

   assign o_rdata = r_rdata;

endmodule : sram_sp

// File: rtl/top_image_sram.sv
// Input-image buffer: one 28x28 image of fixed-point pixel words, host
// load/readback through a single port, range-checked addressing.
// Optional build macro: TOP_ADDR_CHECK_EN enables the addr_err flag;
// otherwise addr_err is tied low (out-of-range accesses are still ignored).
module top_image_sram #(
   parameter int unsigned DEPTH  = top_pkg::IMG_DEPTH,
   parameter int unsigned DATA_W = top_pkg::PIX_W,
   parameter int unsigned ADDR_W = top_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              addr_err,
   output logic              load_done
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic             w_in_range;
   logic             w_last;
   logic             w_we;
   logic             w_re;
   logic             w_clr;
   logic [IDX_W-1:0] w_idx;
   logic             r_load_done;

   // Full-width unsigned compare: high addresses never alias into the array
   assign w_in_range = (address < ADDR_W'(DEPTH));
   assign w_last     = (address == ADDR_W'(DEPTH - 1));
   assign w_idx      = IDX_W'(address);

   // Reset suppresses writes; out-of-range reads clear rdata
   assign w_we  = write & w_in_range & ~reset;
   assign w_re  = ~write & w_in_range & ~reset;
   assign w_clr = reset | (~write & ~w_in_range);

   sram_sp #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_sram (
      .clk     (clk),
      .i_clr   (w_clr),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_idx   (w_idx),
      .i_wdata (wdata),
      .o_rdata (rdata)
   );

   // Sticky flag: last image word has been written since reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_load_done <= 1'b0;
      end else if (w_we && w_last) begin
         r_load_done <= 1'b1;
      end
   end

   assign load_done = r_load_done;

`ifdef TOP_ADDR_CHECK_EN
   logic r_addr_err;

   // Address-error flag tracks the range of the most recent access
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr_err <= 1'b0;
      end else begin
         r_addr_err <= ~w_in_range;
      end
   end

   assign addr_err = r_addr_err;
`else
   assign addr_err = 1'b0;
`endif

endmodule : top_image_sram

// File: tb/tb_top_image_sram.sv
// Self-checking bench for top_image_sram: scoreboard of expected outputs
// pushed when each access is driven, popped after the capturing edge.
module tb_top_image_sram;

   localparam int unsigned DEPTH  = 784;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 16;

`ifdef TOP_ADDR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      string             tag;
      logic [DATA_W-1:0] rd;
      logic              err;
      logic              done;
   } exp_t;

   logic              clk;
   logic              reset;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              addr_err;
   logic              load_done;

   exp_t              sb[$];
   logic [DATA_W-1:0] m_mem [DEPTH];
   logic              m_done;
   logic [DATA_W-1:0] last_rd;
   int                n_vec;
   int                n_miss;

   top_image_sram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .write     (write),
      .address   (address),
      .wdata     (wdata),
      .rdata     (rdata),
      .addr_err  (addr_err),
      .load_done (load_done)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pop the oldest expectation and compare all three outputs against it
   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) begin
         check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check_eq({e.tag, ".rdata"},     32'(rdata),     32'(e.rd));
         check_eq({e.tag, ".addr_err"},  32'(addr_err),  32'(e.err));
         check_eq({e.tag, ".load_done"}, 32'(load_done), 32'(e.done));
      end
   endtask

   function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
      return (a < ADDR_W'(DEPTH)) ? m_mem[a] : '0;
   endfunction

   // One access cycle; rd_exp is used only for reads (writes hold rdata)
   task automatic step(input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rd_exp,
                       input string tag);
      exp_t e;
      @(negedge clk);
      reset   = 1'b0;
      write   = w;
      address = a;
      wdata   = d;
      e.tag = tag;
      e.rd  = w ? last_rd : rd_exp;
      if (w && a < ADDR_W'(DEPTH)) m_mem[a] = d;
      if (w && a == ADDR_W'(DEPTH - 1)) m_done = 1'b1;
      e.err  = ERR_EN && (a >= ADDR_W'(DEPTH));
      e.done = m_done;
      last_rd = e.rd;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   // Reset cycle; any write presented alongside must be suppressed
   task automatic do_reset(input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input string tag);
      exp_t e;
      @(negedge clk);
      reset   = 1'b1;
      write   = w;
      address = a;
      wdata   = d;
      m_done  = 1'b0;
      last_rd = '0;
      e.tag = tag; e.rd = '0; e.err = 1'b0; e.done = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   initial begin
      logic [ADDR_W-1:0] ra;
      n_vec   = 0;
      n_miss  = 0;
      m_done  = 1'b0;
      last_rd = '0;
      reset   = 1'b1;
      write   = 1'b0;
      address = '0;
      wdata   = '0;
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;

      do_reset(1'b0, '0, '0, "reset");

      // Full image load in address order
      for (int i = 0; i < int'(DEPTH); i++) begin
         step(1'b1, ADDR_W'(i), DATA_W'(i) ^ 16'hA5A5, '0, "load");
      end

      // Readback of first, middle and last words
      step(1'b0, 16'd0,   '0, 16'hA5A5, "rd0");
      step(1'b0, 16'd93,  '0, 16'hA5F8, "rd93");
      step(1'b0, 16'd783, '0, 16'hA6AA, "rd783");

      // Out-of-range reads and a write that must not alias
      step(1'b0, 16'd784,   '0, 16'h0000, "oor784");
      step(1'b0, 16'd65535, '0, 16'h0000, "oor65535");
      step(1'b0, 16'd1024,  '0, 16'h0000, "oor1024");
      step(1'b1, 16'd784,   16'hFFFF, '0, "wr784");
      step(1'b0, 16'd783,   '0, 16'hA6AA, "rd783_noalias");
      step(1'b1, 16'd1024,  16'hFFFF, '0, "wr1024");
      step(1'b0, 16'd0,     '0, 16'hA5A5, "rd0_noalias");
      step(1'b0, 16'd783,   '0, 16'hA6AA, "rd783_err_clear");

      // Write followed immediately by read of the same word
      step(1'b1, 16'd93, 16'h1234, '0, "wr93");
      step(1'b0, 16'd93, '0, 16'h1234, "rd93_new");

      // Random mix of reads and writes in a region away from directed words
      for (int i = 0; i < 60; i++) begin
         ra = ADDR_W'($urandom_range(700, 100));
         if ($urandom_range(3, 0) == 0) begin
            step(1'b1, ra, DATA_W'($urandom), '0, "rnd_wr");
         end else if ($urandom_range(7, 0) == 0) begin
            ra = ADDR_W'($urandom_range(65535, 784));
            step(1'b0, ra, '0, 16'h0000, "rnd_oor");
         end else begin
            step(1'b0, ra, '0, model_rd(ra), "rnd_rd");
         end
      end

      // Reset mid-operation with a write pending: write is dropped
      do_reset(1'b1, 16'd5, 16'h0000, "reset_mid");
      step(1'b0, 16'd5, '0, 16'hA5A0, "rd5_kept");

      // Load completion depends only on the last word being written
      do_reset(1'b0, '0, '0, "reset_order");
      step(1'b1, 16'd783, 16'hBEEF, '0, "wr783_only");
      step(1'b0, 16'd783, '0, 16'hBEEF, "rd783_only");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_top_image_sram
